// File: rtl/acc_shift_sequencer_if.sv
// Bundle between a requester/shifter pair and the accumulator shift sequencer.
interface acc_shift_sequencer_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned AMT_W = 4
);
  logic             start;
  logic             dir;
  logic [AMT_W-1:0] amount;
  logic             load;
  logic [N-1:0]     load_data;
  logic [N-1:0]     shf_in;
  logic [2:0]       shf_ctrl;
  logic [N-1:0]     shf_data;
  logic [N-1:0]     acc;
  logic             busy;
  logic             done;

  modport master (
    output start, dir, amount, load, load_data, shf_in,
    input  shf_ctrl, shf_data, acc, busy, done
  );

  modport slave (
    input  start, dir, amount, load, load_data, shf_in,
    output shf_ctrl, shf_data, acc, busy, done
  );
endinterface

// File: rtl/acc_shift_sequencer.sv
// Accumulator owner that breaks an arbitrary shift request into x4 / x2 / zero
// shifter steps, one per cycle, writing the shifter result back each cycle.
module acc_shift_sequencer #(
  parameter int unsigned N     = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  acc_shift_sequencer_if.slave  bus
);
  localparam logic [2:0] CTRL_SHL1 = 3'd0;
  localparam logic [2:0] CTRL_SHR1 = 3'd1;
  localparam logic [2:0] CTRL_PASS = 3'd2;
  localparam logic [2:0] CTRL_SHL2 = 3'd3;
  localparam logic [2:0] CTRL_SHR2 = 3'd4;
  localparam logic [2:0] CTRL_ZERO = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_acc;
  logic [AMT_W-1:0] r_rem;
  logic             r_dir;
  logic             r_clr;
  logic [2:0]       r_shf_ctrl;
  logic             r_busy;
  logic             r_done;

  logic [AMT_W-1:0] w_rem_nxt;
  logic             w_amt_big;

  // Control code for the next step given the remaining distance (rem >= 1).
  function automatic logic [2:0] f_step_ctrl(input logic [AMT_W-1:0] rem,
                                             input logic             d);
    if (rem >= AMT_W'(2)) return d ? CTRL_SHR2 : CTRL_SHL2;
    else                  return d ? CTRL_SHR1 : CTRL_SHL1;
  endfunction

  assign w_amt_big = (32'(bus.amount) >= N);
  assign w_rem_nxt = (r_clr || (r_rem < AMT_W'(2))) ? '0 : (r_rem - AMT_W'(2));

  // Outputs are registered alongside the state, computed for the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_rem      <= '0;
      r_dir      <= 1'b0;
      r_clr      <= 1'b0;
      r_shf_ctrl <= CTRL_PASS;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_acc <= bus.load_data;
          end else if (bus.start) begin
            r_dir  <= bus.dir;
            r_rem  <= bus.amount;
            r_busy <= 1'b1;
            if (bus.amount == '0) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_shf_ctrl <= CTRL_PASS;
            end else if (w_amt_big) begin
              r_state    <= S_SHIFT;
              r_clr      <= 1'b1;
              r_shf_ctrl <= CTRL_ZERO;
            end else begin
              r_state    <= S_SHIFT;
              r_shf_ctrl <= f_step_ctrl(bus.amount, bus.dir);
            end
          end
        end
        S_SHIFT: begin
          r_acc <= bus.shf_in;
          r_rem <= w_rem_nxt;
          r_clr <= 1'b0;
          if (w_rem_nxt == '0) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_shf_ctrl <= CTRL_PASS;
          end else begin
            r_shf_ctrl <= f_step_ctrl(w_rem_nxt, r_dir);
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_shf_ctrl <= CTRL_PASS;
        end
        default: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_clr      <= 1'b0;
          r_shf_ctrl <= CTRL_PASS;
        end
      endcase
    end
  end

  assign bus.acc      = r_acc;
  assign bus.shf_data = r_acc;
  assign bus.shf_ctrl = r_shf_ctrl;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_acc_shift_sequencer.sv
// Bench for acc_shift_sequencer: behavioural shifter plus a request-level reference model.
module tb_acc_shift_sequencer;
  localparam int N     = 8;
  localparam int AMT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  logic [N-1:0] m_acc;

  always #5 clk = ~clk;

  acc_shift_sequencer_if #(.N(N), .AMT_W(AMT_W)) bus ();

  acc_shift_sequencer #(.N(N), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational arithmetic shifter downstream of the accumulator.
  always_comb begin
    case (bus.shf_ctrl)
      3'd0:    bus.shf_in = bus.shf_data << 1;
      3'd1:    bus.shf_in = bus.shf_data >> 1;
      3'd2:    bus.shf_in = bus.shf_data;
      3'd3:    bus.shf_in = bus.shf_data << 2;
      3'd4:    bus.shf_in = bus.shf_data >> 2;
      default: bus.shf_in = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [N-1:0] v);
    bus.load      = 1'b1;
    bus.load_data = v;
    tick();
    bus.load = 1'b0;
    m_acc    = v;
    chk("load_acc", 32'(bus.acc), 32'(v));
    chk("load_busy", 32'(bus.busy), 32'd0);
  endtask

  // One request: step plan from the rules, final value straight from the amount.
  task automatic run_shift(input logic d, input int amt, input bit noise);
    logic [N-1:0] ea[$];
    logic [2:0]   ec[$];
    logic [N-1:0] a;
    logic [N-1:0] exp_final;
    int k, step, lat, exp_lat, idx;
    a = m_acc;
    if (amt >= N) begin
      ec.push_back(3'd5);
      ea.push_back(a);
    end else begin
      k = amt;
      while (k > 0) begin
        step = (k >= 2) ? 2 : 1;
        ec.push_back(d ? ((step == 2) ? 3'd4 : 3'd1) : ((step == 2) ? 3'd3 : 3'd0));
        ea.push_back(a);
        a = d ? (a >> step) : (a << step);
        k -= step;
      end
    end
    exp_final = (amt >= N) ? '0 : (d ? (m_acc >> amt) : (m_acc << amt));
    exp_lat   = (amt == 0) ? 1 : ((amt >= N) ? 2 : 1 + (amt + 1) / 2);

    bus.start  = 1'b1;
    bus.dir    = d;
    bus.amount = AMT_W'(amt);
    tick();
    bus.start = 1'b0;
    lat = 1;
    idx = 0;
    while (!bus.done && lat < 40) begin
      chk("shift_busy", 32'(bus.busy), 32'd1);
      if (idx < ec.size()) begin
        chk("shift_ctrl", 32'(bus.shf_ctrl), 32'(ec[idx]));
        chk("shift_acc", 32'(bus.acc), 32'(ea[idx]));
      end
      idx++;
      if (noise) begin
        bus.load      = 1'($urandom);
        bus.load_data = N'($urandom);
        bus.start     = 1'($urandom);
        bus.dir       = 1'($urandom);
        bus.amount    = AMT_W'($urandom);
      end
      tick();
      lat++;
    end
    bus.load  = 1'b0;
    bus.start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_acc", 32'(bus.acc), 32'(exp_final));
    chk("done_ctrl", 32'(bus.shf_ctrl), 32'd2);
    chk("done_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_acc", 32'(bus.acc), 32'(exp_final));
    m_acc = exp_final;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.dir       = 1'b0;
    bus.amount    = '0;
    bus.load      = 1'b1;
    bus.load_data = 8'h81;

    // Reset with load held: accumulator must stay cleared.
    tick();
    tick();
    chk("rst_acc", 32'(bus.acc), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ctrl", 32'(bus.shf_ctrl), 32'd2);
    rst_n = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("first_load", 32'(bus.acc), 32'h81);
    chk("first_load_ctrl", 32'(bus.shf_ctrl), 32'd2);
    m_acc = 8'h81;

    run_shift(1'b0, 3, 1'b0);
    do_load(8'hF0);
    run_shift(1'b1, 5, 1'b0);
    do_load(8'h5A);
    run_shift(1'b0, 0, 1'b0);
    do_load(8'hFF);
    run_shift(1'b1, 9, 1'b0);

    // Start and load together: load wins, start dropped.
    bus.start     = 1'b1;
    bus.load      = 1'b1;
    bus.load_data = 8'h3C;
    bus.dir       = 1'b0;
    bus.amount    = 4'd3;
    tick();
    bus.start = 1'b0;
    bus.load  = 1'b0;
    chk("contend_acc", 32'(bus.acc), 32'h3C);
    chk("contend_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("contend_busy2", 32'(bus.busy), 32'd0);
    chk("contend_acc2", 32'(bus.acc), 32'h3C);
    m_acc = 8'h3C;

    // Requests during a shift are ignored.
    run_shift(1'b0, 5, 1'b1);

    // Abort in the second SHIFT cycle of a 6-bit shift.
    do_load(8'h55);
    bus.start  = 1'b1;
    bus.dir    = 1'b0;
    bus.amount = 4'd6;
    tick();
    bus.start = 1'b0;
    tick();
    chk("abort_pre_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_acc", 32'(bus.acc), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_ctrl", 32'(bus.shf_ctrl), 32'd2);
    tick();
    chk("abort_no_done", 32'(bus.done), 32'd0);
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    m_acc = '0;
    do_load(8'h0F);
    run_shift(1'b1, 2, 1'b0);

    // Randomised requests with noise on start/load while busy.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) do_load(N'($urandom));
      run_shift(1'($urandom), int'($urandom_range(0, 15)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/acc_shift_sequencer.md
# acc_shift_sequencer

Multi-cycle sequencer that owns the processor's accumulator register and drives the combinational arithmetic shifter directly downstream of it. It turns a single shift request of arbitrary amount into a sequence of shifter control codes, one per cycle. Each cycle it presents the accumulator to the shifter and writes the shifter result back. It also provides a parallel load path into the accumulator.

## Interface
- N, 8, data/accumulator width; must equal the shifter width.
- AMT_W, 4, width of the shift-amount field.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  shift request; sampled only in IDLE.
- dir  in  1  0 = left, 1 = right (logical); sampled with start.
- amount  in  AMT_W  shift distance in bits; sampled with start.
- load  in  1  parallel load of load_data into acc; sampled only in IDLE.
- load_data  in  N  value for load.
- shf_in  in  N  shifter result (combinational from shf_data/shf_ctrl).
- shf_ctrl  out  3  shifter control code.
- shf_data  out  N  shifter operand; always equals acc.
- acc  out  N  accumulator value.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a shift request completes.

## Operation
- States: IDLE, SHIFT, DONE. rem is an AMT_W-bit remaining-distance counter; dir_r is the latched direction.
- IDLE:
  - shf_ctrl = 2 (pass).
  - load=1: acc <= load_data. Load has priority; a start in the same cycle is dropped.
  - start=1 with load=0: latch dir_r <= dir and rem <= amount.
    - amount == 0: go to DONE, acc unchanged.
    - amount >= N: go to SHIFT with a clear flag set.
    - otherwise: go to SHIFT.
- SHIFT (one shifter op per cycle, acc <= shf_in at the clock edge):
  - Clear flag set: shf_ctrl = 5 (zero), rem <= 0, go to DONE.
  - Else if rem >= 2: shf_ctrl = 3 (x4) when dir_r=0, 4 (/4) when dir_r=1; rem <= rem-2.
  - Else (rem == 1): shf_ctrl = 0 (<<1) when dir_r=0, 1 (>>1) when dir_r=1; rem <= 0.
  - Go to DONE when the updated rem is 0; stay in SHIFT otherwise.
- DONE: shf_ctrl = 2, done = 1, acc holds, unconditionally return to IDLE.
- start and load are ignored in SHIFT and DONE (busy=1). Requests are not queued.
- Arithmetic rules:
  - Unsigned and logical; no sign extension.
  - Bits shifted out are lost.
  - x4 and /4 are equivalent to shifting by 2 bits.
- Codes 6 and 7 are never issued.

## Timing
- Reset (rst_n=0 at a clock edge) gives:
  - acc = 0, state = IDLE, rem = 0, dir_r = 0.
  - busy = 0, done = 0, shf_ctrl = 2.
- Reset mid-operation aborts immediately and asserts no done pulse.
- busy, done and shf_ctrl decode from state, rem, dir_r and the clear flag only; no combinational path from start or load.
- Latency from the start edge to the done pulse:
  - 1 + ceil(amount/2) cycles for 0 < amount < N.
  - 2 cycles for amount >= N.
  - 1 cycle for amount = 0.
- acc holds its final value in the done cycle. A new start is accepted from the cycle after done.
- Throughput: one request per (latency + 1) cycles.
- Shifter is combinational: shf_in is valid in the same cycle as shf_ctrl and shf_data. No internal pipeline register on shf_in.

## Test plan
- Reset / load: assert rst_n=0 for 2 cycles, then load=1 with load_data=0x81 -> acc=0x00 during reset, acc=0x81 the next cycle, busy=0, shf_ctrl=2 throughout.
- Left shift: acc=0x81, start with dir=0, amount=3 -> SHIFT cycles show shf_ctrl=3 then 0, acc=0x04 then 0x08, done pulses 3 cycles after start, final acc=0x08.
- Right shift: acc=0xF0, dir=1, amount=5 -> shf_ctrl sequence 4,4,1, acc 0x3C, 0x0F, 0x07, done 4 cycles after start.
- Boundary amounts:
  - amount=0 on acc=0x5A -> done next cycle, acc=0x5A, shf_ctrl never leaves 2.
  - amount=9 on acc=0xFF -> one cycle with shf_ctrl=5, acc=0x00, done 2 cycles after start.
- Contention: start and load in the same IDLE cycle -> acc=load_data, no shift, busy stays 0. start or load during SHIFT -> ignored, acc unaffected by load_data.
- Abort: rst_n=0 during the second SHIFT cycle of amount=6 -> acc=0, busy=0 next cycle, no done pulse; a subsequent start runs normally.
